// File: rtl/axi_bus_arbiter.sv
// axi_bus_arbiter: shares one AXI4-Lite master port between two req/done
// requesters, running exactly one read or write transaction per grant.
module axi_bus_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]  state;
  logic        last_grant;
  logic        gnt;
  logic        any_req;
  logic        win;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [3:0]  win_wstrb;
  logic        aw_ok;
  logic        w_ok;

  // On a tie the round-robin pointer favours whoever was not granted last.
  always_comb begin
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) win = FAIR ? ~last_grant : 1'b0;
    else                  win = ~m0_req;
    win_we    = win ? m1_we    : m0_we;
    win_addr  = win ? m1_addr  : m0_addr;
    win_wdata = win ? m1_wdata : m0_wdata;
    win_wstrb = win ? m1_wstrb : m0_wstrb;
  end

  // A write channel counts as accepted once its valid has dropped or is being taken now.
  assign aw_ok = ~axi_awvalid | axi_awready;
  assign w_ok  = ~axi_wvalid  | axi_wready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      gnt         <= 1'b0;
      axi_araddr  <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      axi_awaddr  <= '0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      m0_rdata    <= '0;
      m0_done     <= 1'b0;
      m0_err      <= 1'b0;
      m1_rdata    <= '0;
      m1_done     <= 1'b0;
      m1_err      <= 1'b0;
    end else begin
      m0_done <= 1'b0;
      m0_err  <= 1'b0;
      m1_done <= 1'b0;
      m1_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt        <= win;
            last_grant <= win;
            if (win_we) begin
              axi_awaddr  <= win_addr;
              axi_wdata   <= win_wdata;
              axi_wstrb   <= win_wstrb;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              state       <= S_WR;
            end else begin
              axi_araddr  <= win_addr;
              axi_arvalid <= 1'b1;
              state       <= S_AR;
            end
          end
        end
        S_AR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= S_R;
          end
        end
        S_R: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            state      <= S_DONE;
            if (gnt) begin
              m1_done  <= 1'b1;
              m1_err   <= |axi_rresp;
              m1_rdata <= axi_rdata;
            end else begin
              m0_done  <= 1'b1;
              m0_err   <= |axi_rresp;
              m0_rdata <= axi_rdata;
            end
          end
        end
        S_WR: begin
          if (axi_awready) axi_awvalid <= 1'b0;
          if (axi_wready)  axi_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            axi_bready <= 1'b1;
            state      <= S_B;
          end
        end
        S_B: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            state      <= S_DONE;
            if (gnt) begin
              m1_done <= 1'b1;
              m1_err  <= |axi_bresp;
            end else begin
              m0_done <= 1'b1;
              m0_err  <= |axi_bresp;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// tb_axi_bus_arbiter: directed bench with a delay-programmable AXI-Lite slave,
// a transaction-level reference model and a fixed-priority companion instance.
module tb_axi_bus_arbiter;

  logic clk = 1'b0;
  logic rstn;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_done, m0_err, m1_done, m1_err;

  logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [1:0]  axi_rresp, axi_bresp;
  logic [3:0]  axi_wstrb;

  logic        f_one;
  logic [31:0] f_rdata_in;
  logic [1:0]  f_resp;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_araddr, f_awaddr, f_wdata;
  logic        f_m0_done, f_m0_err, f_m1_done, f_m1_err;
  logic        f_arvalid, f_rready, f_awvalid, f_wvalid, f_bready;
  logic [3:0]  f_wstrb;

  int ar_dly, aw_dly, w_dly, r_dly, b_dly;
  int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;

  int n_checks = 0;
  int n_fail = 0;

  bit mdl_busy, mdl_first, mdl_own, mdl_we, mdl_last;
  bit ar_acc, aw_acc, w_acc;
  bit exp_v, exp_own, exp_we, exp_err;
  logic [31:0] mdl_addr, mdl_wdata, exp_data;
  logic [3:0]  mdl_wstrb;
  int arv_cnt, b_hs_cnt;
  bit saw_aw_only;
  logic bus_active;

  axi_bus_arbiter #(.FAIR(1'b1)) u_dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  axi_bus_arbiter #(.FAIR(1'b0)) u_fix (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(f_m0_rdata), .m0_done(f_m0_done), .m0_err(f_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(f_m1_rdata), .m1_done(f_m1_done), .m1_err(f_m1_err),
    .axi_araddr(f_araddr), .axi_arvalid(f_arvalid), .axi_arready(f_one),
    .axi_rdata(f_rdata_in), .axi_rresp(f_resp), .axi_rvalid(f_one), .axi_rready(f_rready),
    .axi_awaddr(f_awaddr), .axi_awvalid(f_awvalid), .axi_awready(f_one),
    .axi_wdata(f_wdata), .axi_wstrb(f_wstrb), .axi_wvalid(f_wvalid), .axi_wready(f_one),
    .axi_bresp(f_resp), .axi_bvalid(f_one), .axi_bready(f_bready)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s got=timeout want=event t=%0t", name, $time);
  endtask

  task automatic wait_done(input int who, input int budget, output int cyc);
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk); #2;
      if ((who == 0 && m0_done) || (who == 1 && m1_done)) begin
        cyc = i;
        return;
      end
    end
    cyc = -1;
    timeout("wait_done");
  endtask

  task automatic wait_any(input int budget, output int who);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (m0_done) begin who = 0; return; end
      if (m1_done) begin who = 1; return; end
    end
    who = -1;
    timeout("wait_any");
  endtask

  // Slave: each ready/valid is raised after the programmed number of wait cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (axi_arvalid) begin axi_arready = (ar_cnt >= ar_dly); ar_cnt++; end
      else begin axi_arready = 1'b0; ar_cnt = 0; end
      if (axi_awvalid) begin axi_awready = (aw_cnt >= aw_dly); aw_cnt++; end
      else begin axi_awready = 1'b0; aw_cnt = 0; end
      if (axi_wvalid) begin axi_wready = (w_cnt >= w_dly); w_cnt++; end
      else begin axi_wready = 1'b0; w_cnt = 0; end
      if (axi_rready) begin
        axi_rvalid = (r_cnt >= r_dly); axi_rdata = s_rdata; axi_rresp = s_rresp; r_cnt++;
      end else begin axi_rvalid = 1'b0; r_cnt = 0; end
      if (axi_bready) begin axi_bvalid = (b_cnt >= b_dly); axi_bresp = s_bresp; b_cnt++; end
      else begin axi_bvalid = 1'b0; b_cnt = 0; end
    end
  end

  // Reference model: one transaction at a time, done one cycle after the
  // final handshake, then one quiet cycle before the next grant.
  always @(negedge clk) begin
    #1;
    bus_active = axi_arvalid | axi_rready | axi_awvalid | axi_wvalid | axi_bready;
    if (!rstn) begin
      chk1("rst_quiet", bus_active | m0_done | m1_done, 1'b0);
      mdl_busy = 1'b0; mdl_last = 1'b1; exp_v = 1'b0;
    end else begin
      chk1("m0_done", m0_done, exp_v && !exp_own);
      chk1("m1_done", m1_done, exp_v && exp_own);
      chk1("ar_aw_excl", axi_arvalid && axi_awvalid, 1'b0);
      chk1("fix_ar_aw_excl", f_arvalid && f_awvalid, 1'b0);
      if (axi_arvalid) arv_cnt++;
      if (axi_awvalid && !axi_wvalid) saw_aw_only = 1'b1;
      if (axi_bvalid && axi_bready) b_hs_cnt++;
      if (exp_v) begin
        chk1("err", exp_own ? m1_err : m0_err, exp_err);
        if (!exp_we) chk32("rdata", exp_own ? m1_rdata : m0_rdata, exp_data);
        chk1("done_quiet", bus_active, 1'b0);
        mdl_busy = 1'b0; exp_v = 1'b0;
      end else if (mdl_busy) begin
        if (!mdl_we) begin
          if (mdl_first) chk1("ar_start", axi_arvalid && !axi_awvalid, 1'b1);
          if (axi_arvalid) begin
            chk1("ar_after_acc", ar_acc, 1'b0);
            chk32("araddr", axi_araddr, mdl_addr);
            if (axi_arready) ar_acc = 1'b1;
          end
          if (axi_rvalid && axi_rready) begin
            exp_v = 1'b1; exp_own = mdl_own; exp_we = 1'b0;
            exp_data = axi_rdata; exp_err = |axi_rresp;
          end
        end else begin
          if (mdl_first) chk1("wr_start", axi_awvalid && axi_wvalid && !axi_arvalid, 1'b1);
          if (axi_awvalid) begin
            chk1("aw_after_acc", aw_acc, 1'b0);
            chk32("awaddr", axi_awaddr, mdl_addr);
            if (axi_awready) aw_acc = 1'b1;
          end
          if (axi_wvalid) begin
            chk1("w_after_acc", w_acc, 1'b0);
            chk32("wdata", axi_wdata, mdl_wdata);
            chk32("wstrb", {28'd0, axi_wstrb}, {28'd0, mdl_wstrb});
            if (axi_wready) w_acc = 1'b1;
          end
          if (axi_bvalid && axi_bready) begin
            chk1("b_after_aw_w", aw_acc && w_acc, 1'b1);
            exp_v = 1'b1; exp_own = mdl_own; exp_we = 1'b1; exp_err = |axi_bresp;
          end
        end
        mdl_first = 1'b0;
      end else begin
        chk1("idle_quiet", bus_active, 1'b0);
        if (m0_req || m1_req) begin
          if (m0_req && m1_req) mdl_own = (mdl_last == 1'b0);
          else                  mdl_own = !m0_req;
          mdl_last  = mdl_own;
          mdl_we    = mdl_own ? m1_we : m0_we;
          mdl_addr  = mdl_own ? m1_addr : m0_addr;
          mdl_wdata = mdl_own ? m1_wdata : m0_wdata;
          mdl_wstrb = mdl_own ? m1_wstrb : m0_wstrb;
          mdl_busy = 1'b1; mdl_first = 1'b1;
          ar_acc = 1'b0; aw_acc = 1'b0; w_acc = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, n, f0, f1;
    int got [4];
    rstn = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
    ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0; b_dly = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    s_rdata = 0; s_rresp = 0; s_bresp = 0;
    f_one = 1'b1; f_rdata_in = 32'h0F0F0F0F; f_resp = 2'b00;
    arv_cnt = 0; b_hs_cnt = 0; saw_aw_only = 0;

    repeat (3) @(negedge clk);
    #2;
    chk32("rst_araddr", axi_araddr, 32'h0);
    chk32("rst_awaddr", axi_awaddr, 32'h0);
    chk32("rst_m0_rdata", m0_rdata, 32'h0);
    chk32("rst_wstrb", {28'd0, axi_wstrb}, 32'h0);
    chk1("rst_arvalid", axi_arvalid, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // m0 read with arready two cycles late
    @(negedge clk);
    ar_dly = 2; s_rdata = 32'hDEADBEEF; m0_addr = 32'h100; m0_we = 0; m0_req = 1; arv_cnt = 0;
    wait_done(0, 20, cyc);
    chk32("t2_latency", cyc, 32'd5);
    chk32("t2_rdata", m0_rdata, 32'hDEADBEEF);
    chk1("t2_err", m0_err, 1'b0);
    m0_req = 0; ar_dly = 0;
    @(negedge clk); #2;
    chk1("t2_done_width", m0_done, 1'b0);
    chk32("t2_arvalid_cycles", arv_cnt, 32'd3);
    repeat (3) @(negedge clk);

    // zero-wait read, request held through done
    @(negedge clk);
    s_rdata = 32'h00C0FFEE; m0_addr = 32'h400; m0_req = 1;
    wait_done(0, 10, cyc);
    chk32("t7_latency", cyc, 32'd3);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2; n++;
      if (axi_arvalid) break;
    end
    chk32("t7_rearb_gap", n, 32'd2);
    wait_done(0, 10, cyc);
    chk32("t7_second_done", cyc, 32'd2);
    m0_req = 0;
    repeat (3) @(negedge clk);

    // m1 write, wready one cycle ahead of awready
    @(negedge clk);
    aw_dly = 1; w_dly = 0; s_bresp = 2'b00; b_hs_cnt = 0; saw_aw_only = 0;
    m1_addr = 32'h200; m1_wdata = 32'h12345678; m1_wstrb = 4'hF; m1_we = 1; m1_req = 1;
    wait_done(1, 20, cyc);
    chk32("t3_latency", cyc, 32'd4);
    chk1("t3_err", m1_err, 1'b0);
    chk1("t3_m0_quiet", m0_done, 1'b0);
    chk1("t3_w_first", saw_aw_only, 1'b1);
    m1_req = 0; aw_dly = 0;
    @(negedge clk); #2;
    chk32("t3_single_b", b_hs_cnt, 32'd1);
    repeat (3) @(negedge clk);

    // write with SLVERR, then a clean read
    @(negedge clk);
    s_bresp = 2'b10; m1_addr = 32'h300; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'h3; m1_we = 1; m1_req = 1;
    wait_done(1, 10, cyc);
    chk32("t5_latency", cyc, 32'd3);
    chk1("t5_err_with_done", m1_err, 1'b1);
    m1_req = 0;
    @(negedge clk);
    s_bresp = 2'b00;
    @(negedge clk);
    s_rdata = 32'hCAFEF00D; m1_addr = 32'h304; m1_we = 0; m1_req = 1;
    wait_done(1, 10, cyc);
    chk1("t5_next_err", m1_err, 1'b0);
    chk32("t5_next_rdata", m1_rdata, 32'hCAFEF00D);
    m1_req = 0;
    repeat (3) @(negedge clk);

    // both requesting continuously: round-robin alternation
    @(negedge clk);
    s_rdata = 32'h11112222;
    m0_addr = 32'h1000; m0_we = 0; m1_addr = 32'h2000; m1_we = 0;
    m0_req = 1; m1_req = 1;
    for (int k = 0; k < 4; k++) wait_any(12, got[k]);
    m0_req = 0; m1_req = 0;
    chk32("t4_grant0", got[0], 32'd0);
    chk32("t4_grant1", got[1], 32'd1);
    chk32("t4_grant2", got[2], 32'd0);
    chk32("t4_grant3", got[3], 32'd1);
    repeat (10) @(negedge clk);

    // fixed priority companion: m1 starves while m0 keeps requesting
    @(negedge clk);
    m0_req = 1; m1_req = 1; f0 = 0; f1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #3;
      if (f_m0_done) f0++;
      if (f_m1_done) f1++;
    end
    chk32("fix_m0_grants", f0, 32'd3);
    chk32("fix_m1_grants", f1, 32'd0);
    m0_req = 0;
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #3;
      if (f_m1_done) begin n = i; break; end
    end
    if (n < 0) timeout("fix_m1_after_release");
    else begin
      chk32("fix_m1_rdata", f_m1_rdata, 32'h0F0F0F0F);
      chk1("fix_m1_err", f_m1_err, 1'b0);
    end
    m1_req = 0;
    repeat (10) @(negedge clk);

    // reset while waiting for rvalid
    @(negedge clk);
    r_dly = 6; s_rdata = 32'h55AA55AA; m0_addr = 32'h500; m0_we = 0; m0_req = 1;
    n = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (axi_rready) begin n = i; break; end
    end
    if (n < 0) timeout("t6_reach_r");
    @(negedge clk); #3;
    rstn = 1'b0;
    #1;
    chk1("t6_rready_async", axi_rready, 1'b0);
    chk1("t6_arvalid_async", axi_arvalid, 1'b0);
    chk1("t6_awvalid_async", axi_awvalid | axi_wvalid | axi_bready, 1'b0);
    m0_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk1("t6_no_done", m0_done, 1'b0);
    end
    @(negedge clk);
    rstn = 1'b1; r_dly = 0;
    @(negedge clk); #2;
    chk1("t6_idle_after", axi_arvalid, 1'b0);
    @(negedge clk);
    s_rdata = 32'h13579BDF; m0_addr = 32'h504; m0_req = 1;
    wait_done(0, 10, cyc);
    chk32("t6_recover_latency", cyc, 32'd3);
    chk32("t6_recover_rdata", m0_rdata, 32'h13579BDF);
    m0_req = 0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
